// File: rtl/conv_8x32_shift_add_mac.sv
// Sequential shift-and-add multiplier feeding a wrapping convolution accumulator.
// One product per start: DATA_WIDTH MULT iterations, then one ACC cycle.
module conv_8x32_shift_add_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    clear_i,
  input  logic [DATA_WIDTH-1:0]   a_in,
  input  logic [DATA_WIDTH-1:0]   b_in,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2*DATA_WIDTH-1:0] product_o,
  output logic [ACC_WIDTH-1:0]    acc_o
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_ACC
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PW-1:0]           product_q, product_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   partial;
  logic [ACC_WIDTH-1:0]    product_ext;

  assign partial     = a_q & {DATA_WIDTH{b_q[0]}};
  assign product_ext = {{(ACC_WIDTH - PW){1'b0}}, product_q};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    count_d   = count_q;
    product_d = product_q;
    acc_d     = acc_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (clear_i) acc_d = '0;
        if (start_i) begin
          a_d       = a_in;
          b_d       = b_in;
          product_d = '0;
          count_d   = '0;
          state_d   = S_MULT;
        end
      end
      S_MULT: begin
        if (clear_i) acc_d = '0;
        product_d = product_q + (PW'(partial) << count_q);
        b_d       = b_q >> 1;
        count_d   = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) state_d = S_ACC;
      end
      S_ACC: begin
        // A clear here restarts the sum with the product just finished.
        acc_d   = clear_i ? product_ext : acc_q + product_ext;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      count_q   <= count_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign product_o = product_q;
  assign acc_o     = acc_q;

endmodule

// File: tb/tb_conv_8x32_shift_add_mac.sv
// Self-checking bench: directed and random multiplies against an arithmetic model
// of the product and the wrapping 24-bit accumulator.
module tb_conv_8x32_shift_add_mac;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        clear_i;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy_o;
  logic        done_o;
  logic [15:0] product_o;
  logic [23:0] acc_o;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_acc = '0;

  conv_8x32_shift_add_mac #(.DATA_WIDTH(8), .ACC_WIDTH(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .clear_i   (clear_i),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o),
    .acc_o     (acc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts one multiply at the current negedge and returns at the negedge where done_o is seen.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input bit clr_in_acc, input bit inject_start);
    int  lat;
    int  busy_cnt;
    bit  seen;
    logic [15:0] p;
    start_i  = 1'b1;
    a_in     = a;
    b_in     = b;
    seen     = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      clear_i = 1'b0;
      a_in    = 8'($urandom);
      b_in    = 8'($urandom);
      if (cyc == 1) check("product_zeroed_on_start", product_o, 0);
      if (inject_start && cyc == 3) begin
        start_i = 1'b1;
        a_in    = 8'd1;
        b_in    = 8'd1;
      end
      if (clr_in_acc && cyc == 9) clear_i = 1'b1;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        seen = 1'b1;
        lat  = cyc - 1;
      end
    end
    clear_i = 1'b0;
    p       = 16'(a) * 16'(b);
    exp_acc = clr_in_acc ? 24'(p) : exp_acc + 24'(p);
    check("done_seen", 32'(seen), 1);
    check("done_latency", lat, 9);
    check("busy_cycles", busy_cnt, 9);
    check("product", product_o, p);
    check("acc", acc_o, exp_acc);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done_o) n++;
    end
    check(tag, n, 0);
  endtask

  task automatic clear_idle();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    exp_acc = '0;
    check("clear_idle_acc", acc_o, 0);
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    clear_i = 1'b0;
    a_in    = '0;
    b_in    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_product", product_o, 0);
    check("rst_acc", acc_o, 0);

    do_op(8'd5, 8'd3, 1'b0, 1'b0);
    check("basic_acc_15", acc_o, 15);

    // A start during MULT must be ignored entirely.
    do_op(8'd7, 8'd9, 1'b0, 1'b1);
    expect_no_done("no_extra_done", 12);
    check("ignored_start_acc", acc_o, 78);

    clear_idle();
    do_op(8'd10, 8'd10, 1'b0, 1'b0);
    check("acc_100", acc_o, 100);
    do_op(8'd12, 8'd12, 1'b1, 1'b0);
    check("clear_in_acc_144", acc_o, 144);
    clear_idle();

    for (int i = 0; i < 32; i++) do_op(8'd255, 8'd255, 1'b0, 1'b0);
    check("full_scale_acc", acc_o, 24'h1FC020);

    do_op(8'd0, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      do_op(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    do_op(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    start_i = 1'b1;
    a_in    = 8'd200;
    b_in    = 8'd200;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy_o, 0);
    check("async_rst_done", done_o, 0);
    check("async_rst_product", product_o, 0);
    check("async_rst_acc", acc_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    exp_acc = '0;
    expect_no_done("no_done_after_abort", 12);
    do_op(8'd2, 8'd2, 1'b0, 1'b0);
    check("post_reset_acc_4", acc_o, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
